// File: rtl/qspi_flash_read_controller.sv
// Quad-SPI flash read controller: issues Fast Read Quad Output (0x6B) at a
// byte address, then streams words assembled from 4-bit nibbles. Streaming
// can be stalled between words or aborted at any point.
module qspi_flash_read_controller #(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ADDR_BITS        = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    spi_data_in,
  output logic [3:0]                    spi_data_out,
  output logic [3:0]                    spi_data_oe,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic                          start_read,
  input  logic                          stall_read,
  input  logic                          stop_read,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_ready,
  output logic                          busy
);

  localparam int WORD_BITS  = 8 * DATA_WIDTH_BYTES;
  localparam int SHIFT_BITS = 8 + ADDR_BITS;
  localparam int CNT_W      = 8;

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] NIB_LAST   = CNT_W'(2 * DATA_WIDTH_BYTES - 1);
  localparam logic [7:0]       READ_CMD   = 8'h6B;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    STALL
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    sck;
  logic                    sck_next;
  logic                    shifting;
  logic                    word_done;
  logic                    load_word;
  logic [CNT_W-1:0]        cnt;
  logic [SHIFT_BITS-1:0]   shreg;
  logic [3:0]              hi_nib;
  logic [WORD_BITS-1:0]    collect;
  logic [WORD_BITS+7:0]    assembled;

  assign spi_clk_out = sck;

  // Next-state decode and pin outputs; SCK toggles only in shifting states,
  // and stop_read overrides every transition out of a busy state.
  always_comb begin
    state_next   = state;
    shifting     = 1'b0;
    word_done    = 1'b0;
    sck_next     = 1'b0;
    load_word    = 1'b0;
    spi_select   = 1'b1;
    busy         = 1'b0;
    spi_data_out = 4'b0000;
    spi_data_oe  = 4'b0000;
    assembled    = {hi_nib, spi_data_in, collect};

    case (state)
      IDLE: begin
        if (start_read) state_next = CMD;
      end
      CMD: begin
        shifting     = 1'b1;
        spi_select   = 1'b0;
        busy         = 1'b1;
        spi_data_oe  = 4'b0001;
        spi_data_out = {3'b000, shreg[SHIFT_BITS-1]};
        if (sck && cnt == CMD_LAST) state_next = ADDR;
      end
      ADDR: begin
        shifting     = 1'b1;
        spi_select   = 1'b0;
        busy         = 1'b1;
        spi_data_oe  = 4'b0001;
        spi_data_out = {3'b000, shreg[SHIFT_BITS-1]};
        if (sck && cnt == ADDR_LAST) state_next = DUMMY;
      end
      DUMMY: begin
        shifting   = 1'b1;
        spi_select = 1'b0;
        busy       = 1'b1;
        if (sck && cnt == DUMMY_LAST) state_next = DATA;
      end
      DATA: begin
        shifting   = 1'b1;
        spi_select = 1'b0;
        busy       = 1'b1;
        word_done  = sck && (cnt == NIB_LAST);
        if (word_done) state_next = stall_read ? STALL : DATA;
      end
      STALL: begin
        spi_select = 1'b0;
        busy       = 1'b1;
        if (!stall_read) state_next = DATA;
      end
      default: state_next = IDLE;
    endcase

    if (state != IDLE && stop_read) state_next = IDLE;

    sck_next  = shifting && !sck && state_next != IDLE && state_next != STALL;
    load_word = word_done && state_next != IDLE;
  end

  // State register plus datapath: bit/nibble counter, command/address
  // shifter, nibble assembly, and the delivered word with its ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sck        <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      hi_nib     <= 4'h0;
      collect    <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
    end else begin
      state <= state_next;
      sck   <= sck_next;

      if (state == IDLE) begin
        cnt <= '0;
        if (start_read) shreg <= {READ_CMD, addr_in};
      end else if (shifting && sck) begin
        cnt <= (state_next != state || word_done) ? '0 : cnt + 1'b1;
        if (state == CMD || state == ADDR) shreg <= shreg << 1;
        if (state == DATA) begin
          if (!cnt[0]) hi_nib <= spi_data_in;
          else         collect <= assembled[WORD_BITS+7:8];
        end
      end

      if (load_word) data_out <= assembled[WORD_BITS+7:8];

      if (state_next == IDLE)           data_ready <= 1'b0;
      else if (load_word)               data_ready <= 1'b1;
      else if (state == DATA && !sck)   data_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qspi_flash_read_controller.sv
// Bench for qspi_flash_read_controller: two instances (1- and 2-byte words)
// share control inputs; each has its own flash image. A transaction-level
// model predicts every pin each cycle, and literal expectations pin it.
module tb_qspi_flash_read_controller;

  localparam int AB = 24;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_read;
  logic        stall_read;
  logic        stop_read;
  logic [23:0] addr_in;

  logic [3:0]  sd_in0, sd_in1;
  logic [3:0]  sdo0, sdo1, oe0, oe1;
  logic        sel0, sel1, sck0, sck1, rdy0, rdy1, busy0, busy1;
  logic [7:0]  dout0;
  logic [15:0] dout1;

  logic [7:0]  mem [2][256];

  bit          m_active  [2];
  bit          m_stalled [2];
  bit          m_ready   [2];
  int          m_k       [2];
  logic [23:0] m_addr    [2];
  logic [15:0] m_dout    [2];

  int          cyc = 0;
  int          start_cyc = 0;
  int          scen = 0;
  int          t;
  int          mb, mn, mnw;
  int          dn;
  logic [7:0]  db;
  logic [31:0] cap = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  qspi_flash_read_controller #(.DATA_WIDTH_BYTES(1), .ADDR_BITS(AB)) dut_w1 (
    .clk(clock), .reset(reset), .spi_data_in(sd_in0), .spi_data_out(sdo0),
    .spi_data_oe(oe0), .spi_select(sel0), .spi_clk_out(sck0),
    .addr_in(addr_in), .start_read(start_read), .stall_read(stall_read),
    .stop_read(stop_read), .data_out(dout0), .data_ready(rdy0), .busy(busy0)
  );

  qspi_flash_read_controller #(.DATA_WIDTH_BYTES(2), .ADDR_BITS(AB)) dut_w2 (
    .clk(clock), .reset(reset), .spi_data_in(sd_in1), .spi_data_out(sdo1),
    .spi_data_oe(oe1), .spi_select(sel1), .spi_clk_out(sck1),
    .addr_in(addr_in), .start_read(start_read), .stall_read(stall_read),
    .stop_read(stop_read), .data_out(dout1), .data_ready(rdy1), .busy(busy1)
  );

  // Word w of a transaction starting at address a, lowest address in [7:0].
  function automatic logic [15:0] word_at(int i, logic [23:0] a, int w);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j <= i; j++)
      r[8*j +: 8] = mem[i][(int'(a[7:0]) + w * (i + 1) + j) % 256];
    return r;
  endfunction

  // Expected pins {sel, busy, sck, oe, sd, ready, dout} from the model.
  function automatic logic [27:0] expected(int i);
    logic [7:0] cmd;
    logic [3:0] oe_e, sd_e;
    logic       sck_e;
    int         b;
    cmd  = 8'h6B;
    oe_e = 4'b0000;
    sd_e = 4'b0000;
    if (!m_active[i]) return {1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, m_ready[i], m_dout[i]};
    sck_e = (m_k[i] % 2 == 1) && !m_stalled[i];
    b = m_k[i] / 2;
    if (b < 8) begin
      oe_e = 4'b0001;
      sd_e = {3'b000, cmd[7-b]};
    end else if (b < 8 + AB) begin
      oe_e = 4'b0001;
      sd_e = {3'b000, m_addr[i][AB-1-(b-8)]};
    end
    return {1'b0, 1'b1, sck_e, oe_e, sd_e, m_ready[i], m_dout[i]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic st, input logic stl,
                                input logic stp, input logic [23:0] a);
    reset      = rst;
    start_read = st;
    stall_read = stl;
    stop_read  = stp;
    addr_in    = a;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Transaction model: k counts SCK half-periods since chip select; a stall
  // freezes k, word completions are computed from the flash image directly.
  always @(posedge clock) begin
    if (!reset && !m_active[0] && start_read) start_cyc = cyc;
    for (int i = 0; i < 2; i++) begin
      mnw = 2 * (i + 1);
      if (reset) begin
        m_active[i]  = 0;
        m_stalled[i] = 0;
        m_ready[i]   = 0;
        m_dout[i]    = '0;
      end else if (!m_active[i]) begin
        if (start_read) begin
          m_active[i]  = 1;
          m_stalled[i] = 0;
          m_k[i]       = 0;
          m_addr[i]    = addr_in;
        end
      end else if (stop_read) begin
        m_active[i] = 0;
        m_ready[i]  = 0;
      end else if (m_stalled[i]) begin
        if (!stall_read) m_stalled[i] = 0;
      end else begin
        mb = m_k[i] / 2;
        if (m_k[i] % 2 == 1 && mb >= 16 + AB) begin
          mn = mb - 16 - AB;
          if (mn % mnw == mnw - 1) begin
            m_dout[i]  = word_at(i, m_addr[i], mn / mnw);
            m_ready[i] = 1;
            if (stall_read) m_stalled[i] = 1;
          end
        end
        m_k[i]++;
        if (m_k[i] % 2 == 1) m_ready[i] = 0;
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model and literal expectations, then
  // the flash drives the nibble due in this cycle (junk when none is due).
  always @(negedge clock) begin
    #1;
    t = cyc - start_cyc;
    check_output("pins_w1", {4'h0, sel0, busy0, sck0, oe0, sdo0, rdy0, 8'h00, dout0}, {4'h0, expected(0)});
    check_output("pins_w2", {4'h0, sel1, busy1, sck1, oe1, sdo1, rdy1, dout1}, {4'h0, expected(1)});

    case (scen)
      0: check_output("idle_pins", {sel0, sck0, oe0, busy0, rdy0, sel1, sck1, oe1, busy1, rdy1},
                      {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
      1: begin
        if (t == 64) check_output("oe_c64", oe0, 4'b0001);
        if (t == 65) begin
          check_output("oe_c65", oe0, 4'b0000);
          check_output("sd0_stream", cap, 32'h6B100ABC);
        end
        if (t == 84) check_output("rdy_c84", rdy0, 1'b0);
        if (t == 85) check_output("word0_c85", {rdy0, dout0}, {1'b1, 8'hA5});
        if (t == 87) check_output("rdy_c87", rdy0, 1'b0);
        if (t == 88) check_output("w2_rdy_c88", rdy1, 1'b0);
        if (t == 89) begin
          check_output("word1_c89", {rdy0, dout0}, {1'b1, 8'h3C});
          check_output("w2_word_c89", {rdy1, dout1}, {1'b1, 16'h2211});
        end
      end
      2: begin
        if (t == 100) check_output("stall_hold", {sel0, sck0, rdy0, dout0}, {1'b0, 1'b0, 1'b1, 8'hA5});
        if (t == 109) check_output("stall_resume_pre", {rdy0, dout0}, {1'b0, 8'hA5});
        if (t == 110) check_output("stall_resume_word", {rdy0, dout0}, {1'b1, 8'h3C});
      end
      3: if (t == 41) check_output("abort_idle", {sel0, busy0, sck0, oe0, rdy0}, {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
      4: if (t == 65) check_output("restart_stream", cap, 32'h6B5A5A5A);
      default: ;
    endcase

    if (t == 1) cap = '0;
    else if (sck0) cap = {cap[30:0], sdo0[0]};

    sd_in0 = 4'($urandom);
    sd_in1 = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (m_active[i] && !m_stalled[i] && m_k[i] % 2 == 1 && m_k[i] / 2 >= 16 + AB) begin
        dn = m_k[i] / 2 - 16 - AB;
        db = mem[i][(int'(m_addr[i][7:0]) + dn / 2) % 256];
        if (i == 0) sd_in0 = (dn % 2 == 0) ? db[7:4] : db[3:0];
        else        sd_in1 = (dn % 2 == 0) ? db[7:4] : db[3:0];
      end
    end
  end

  // Directed scenarios (basic read, stall, abort/restart) then random traffic.
  initial begin
    logic stl;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) mem[i][a] = 8'($urandom);
    mem[0][8'hBC] = 8'hA5;
    mem[0][8'hBD] = 8'h3C;
    mem[1][8'hBC] = 8'h11;
    mem[1][8'hBD] = 8'h22;
    sd_in0 = 4'h0;
    sd_in1 = 4'h0;

    apply_stimulus(1, 0, 0, 0, 24'h0);
    tick(3);
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(10);

    apply_stimulus(0, 1, 0, 0, 24'h100ABC);
    tick(1);
    scen = 1;
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(95);
    apply_stimulus(0, 0, 0, 1, 24'h0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(3);

    apply_stimulus(0, 1, 0, 0, 24'h100ABC);
    tick(1);
    scen = 2;
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(79);
    apply_stimulus(0, 0, 1, 0, 24'h0);
    tick(25);
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(15);
    apply_stimulus(0, 0, 0, 1, 24'h0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(3);

    apply_stimulus(0, 1, 0, 0, 24'h123456);
    tick(1);
    scen = 3;
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(39);
    apply_stimulus(0, 0, 0, 1, 24'h0);
    tick(1);
    apply_stimulus(0, 1, 0, 0, 24'h5A5A5A);
    tick(1);
    scen = 4;
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(9);
    apply_stimulus(0, 1, 0, 0, 24'hFFFFFF);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(60);
    apply_stimulus(0, 0, 0, 1, 24'h0);
    tick(1);
    scen = 5;
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(2);

    stl = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 7) == 0) stl = ~stl;
      apply_stimulus($urandom_range(0, 599) == 0, $urandom_range(0, 39) == 0, stl,
                     $urandom_range(0, 199) == 0, 24'($urandom));
      tick(1);
    end
    apply_stimulus(0, 0, 0, 0, 24'h0);
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_flash_read_controller.md
# qspi_flash_read_controller

Read-only controller for the quad-SPI flash that holds the cartridge ROM image. It sits between the console's ROM request logic and the QSPI PMOD pins. On a start request it issues a Fast Read Quad Output command (0x6B) at a given byte address, then streams consecutive data words. Streaming can be paused (stalled) or aborted, so the host can track sequential ROM fetches and restart on a miss.

## Interface
- `DATA_WIDTH_BYTES`, default 1: bytes per delivered word.
- `ADDR_BITS`, default 24: flash address width, sent MSB first.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `spi_data_in` in 4: SD3..SD0 from flash.
- `spi_data_out` out 4: SD3..SD0 to flash.
- `spi_data_oe` out 4: per-line output enable, 1 = drive.
- `spi_select` out 1: flash chip select, active low.
- `spi_clk_out` out 1: SCK.
- `addr_in` in ADDR_BITS: start byte address, sampled with `start_read`.
- `start_read` in 1: begin a read; honoured only while `busy`=0.
- `stall_read` in 1: pause streaming after the current word.
- `stop_read` in 1: abort the transaction.
- `data_out` out 8*DATA_WIDTH_BYTES: last completed word. Lowest-address byte is in bits [7:0].
- `data_ready` out 1: `data_out` holds a new, valid word.
- `busy` out 1: a transaction is open (CS asserted).

## Operation
- Reset values: `spi_select`=1, `spi_clk_out`=0, `spi_data_out`=0, `spi_data_oe`=0, `data_out`=0, `data_ready`=0, `busy`=0. The state machine enters IDLE.
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> (STALL <-> DATA) -> IDLE.
- Every SPI bit or nibble takes two clk cycles:
  - low phase: `spi_clk_out`=0; outputs change here.
  - high phase: `spi_clk_out`=1; `spi_data_in` is sampled on the clk edge that ends the high phase.
- IDLE: `start_read`=1 latches `addr_in` and moves to CMD.
- CMD: sends 0x6B MSB first on SD0. `spi_data_oe`=4'b0001.
- ADDR: sends ADDR_BITS address bits MSB first on SD0. `spi_data_oe`=4'b0001.
- DUMMY: 8 SCK cycles. `spi_data_oe`=0, `spi_data_out`=0.
- DATA:
  - Each byte takes 2 SCK cycles: high nibble first, then low nibble, taken from `spi_data_in[3:0]`.
  - Nibbles shift into a collection register; `data_out` does not change until a whole word completes.
  - At word completion, `data_out` is loaded and `data_ready` is set.
- Continuing after a completed word:
  - If `stall_read`=0 in the completion cycle, the next word starts immediately (next low phase follows).
  - If `stall_read`=1, enter STALL: SCK held low, CS stays low, `data_ready` stays 1, `data_out` is held.
  - While in STALL, `stall_read`=0 resumes DATA on the next cycle.
- `data_ready` clears on the first cycle SCK toggles for the next word.
- The flash address auto-increments; the controller does not track the address.
- `stop_read`=1 in any non-IDLE state has priority over everything. On the next cycle: IDLE, `spi_select`=1, `spi_clk_out`=0, `spi_data_oe`=0, `data_ready`=0, `busy`=0. `data_out` retains its value.
- `start_read` while `busy`=1 is ignored. `start_read` and `stop_read` together in IDLE: start wins.
- `reset` mid-transaction forces the reset values on the next edge.

## Timing
- Cycle 0 (`start_read` sampled in IDLE):
  - cycle 1: `spi_select`=0, `busy`=1, SD0 = command bit 7, SCK low.
  - cycle 2: first SCK high.
- Cycles per phase with default parameters:
  - CMD: cycles 1-16.
  - ADDR: cycles 17-64.
  - DUMMY: cycles 65-80.
  - first byte: cycles 81-84.
- `data_ready` first rises at cycle 85. General formula: 1 + 2*(16 + ADDR_BITS + 2*DATA_WIDTH_BYTES).
- Unstalled streaming produces one word every 4*DATA_WIDTH_BYTES cycles.
- `data_ready` is high for at least one cycle per word.
- SCK frequency is clk/2; SCK is never high for more than one cycle.
- `stop_read` -> `busy`=0 after 1 cycle. `start_read` is accepted again in the following cycle.

## Test plan
- Reset then idle, checked for 10 cycles: `spi_select`=1, `spi_clk_out`=0, `spi_data_oe`=0, `busy`=0, `data_ready`=0.
- `addr_in`=0x100ABC with `start_read` pulse:
  - SD0 serial stream equals 0x6B, then 0x100ABC, sampled on SCK rising.
  - `spi_data_oe`=0001 through cycle 64, then 0000.
- Flash model returns bytes 0xA5, 0x3C: `data_ready` rises at cycle 85 with `data_out`=0xA5, then 4 cycles later `data_out`=0x3C.
- Stall during streaming:
  - Hold `stall_read`=1 after the first word for 20 cycles: SCK stays low, `data_ready`=1, `data_out`=0xA5 held.
  - Release: the next byte 0x3C arrives 4 cycles after release.
- Abort and restart:
  - `stop_read` at cycle 40: next cycle `spi_select`=1, `busy`=0.
  - A fresh `start_read` restarts with command 0x6B.
  - A `start_read` while busy is ignored: no change to the address stream.
- `DATA_WIDTH_BYTES`=2 with bytes 0x11, 0x22: `data_out`=0x2211, `data_ready` at cycle 89.
